// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared defaults and state encoding for the multiplier pipe stage
//   Defines the default lane/tag width, default lane count and the three-state
//   occupancy encoding used by mult_pipe_stage.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_LANES = 8;

    // Encoding doubles as the occupancy count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_pipe_slot.sv
// rtl/mult_pipe_slot.sv - one beat-wide holding register with load enable
//   clock : rising-edge clock
//   reset : asynchronous active-high clear of the held beat
//   load  : capture d on the next rising edge
//   d     : beat to capture
//   q     : held beat
module mult_pipe_slot #(
    parameter int BEAT_W = 288
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [BEAT_W-1:0] d,
    output logic [BEAT_W-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mult_pipe_stage.sv
// rtl/mult_pipe_stage.sv - two-slot skid buffer carrying partial-product lanes plus a tag
//   clock/reset          : rising-edge clock, asynchronous active-high reset
//   flush                : synchronous discard of held beats (slot data untouched)
//   in_valid/in_ready    : upstream handshake; in_ready is registered
//   in_lanes/in_tag      : incoming beat, lane k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready  : downstream handshake; out_valid is registered
//   out_lanes/out_tag    : beat held in MAIN
//   occupancy            : number of held beats (0..2)
module mult_pipe_stage
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LANES = DEFAULT_LANES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_lanes,
    input  logic [WIDTH-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_lanes,
    output logic [WIDTH-1:0]       out_tag,
    output logic [1:0]             occupancy
);

    localparam int BEAT_W = LANES * WIDTH + WIDTH;

    state_t              state;
    state_t              state_next;
    logic                in_xfer;
    logic                out_xfer;
    logic                main_load;
    logic                skid_load;
    logic [BEAT_W-1:0]   in_beat;
    logic [BEAT_W-1:0]   main_d;
    logic [BEAT_W-1:0]   main_q;
    logic [BEAT_W-1:0]   skid_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Lanes and tag travel as a single word so they can never slip apart.
    assign in_beat = {in_tag, in_lanes};

    // Flush blocks every load: held data stays put, only the state is discarded.
    always_comb begin
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = in_beat;
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_load  = 1'b1;
                        state_next = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load  = 1'b1;
                        state_next = ST_FULL;
                    end else if (out_xfer) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_xfer) begin
                        main_load  = 1'b1;
                        main_d     = skid_q;
                        state_next = ST_HALF;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state so neither
    // in_ready nor out_valid depends combinationally on the peer's signal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next != ST_EMPTY);
            in_ready  <= (state_next != ST_FULL);
        end
    end

    assign occupancy = state;

    mult_pipe_slot #(
        .BEAT_W (BEAT_W)
    ) u_main (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    mult_pipe_slot #(
        .BEAT_W (BEAT_W)
    ) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .d     (in_beat),
        .q     (skid_q)
    );

    assign out_lanes = main_q[LANES*WIDTH-1:0];
    assign out_tag   = main_q[BEAT_W-1:LANES*WIDTH];

endmodule
